// File: rtl/graph_mem_loader_if.sv
// Stream and memory-bus bundle shared by graph_mem_loader and its neighbours.
// Handshake rules, for all three channels:
//   - in_valid/in_ready and out_valid/out_ready: a word moves on a rising clock
//     edge where both are high. The sender holds the payload stable while valid
//     is high and ready is low.
//   - mem_write_enable/mem_write_ready and mem_read_enable/mem_read_ready: the
//     requester holds the enable, mem_addr and mem_write_data stable until the
//     ready is sampled high. The read data is taken in the cycle mem_read_ready is high.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

interface graph_mem_loader_if #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [VALUE_WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [MDATA_WIDTH-1:0] out_data;
  logic                   mem_read_enable;
  logic                   mem_write_enable;
  logic                   mem_write_ready;
  logic                   mem_read_ready;
  logic [MADDR_WIDTH-1:0] mem_addr;
  logic [MDATA_WIDTH-1:0] mem_read_data;
  logic [MDATA_WIDTH-1:0] mem_write_data;

  // Loader side: consumes the edge stream, produces the dump stream, masters memory.
  modport master (
    input  in_valid, in_data, out_ready, mem_write_ready, mem_read_ready, mem_read_data,
    output in_ready, out_valid, out_data, mem_read_enable, mem_write_enable,
           mem_addr, mem_write_data
  );

  // Host/memory side.
  modport slave (
    output in_valid, in_data, out_ready, mem_write_ready, mem_read_ready, mem_read_data,
    input  in_ready, out_valid, out_data, mem_read_enable, mem_write_enable,
           mem_addr, mem_write_data
  );
endinterface

// File: rtl/graph_mem_loader.sv
// Memory sequencer: loads an N x N edge matrix from a stream into BlockRam
// (optionally verifying each word by read-back) or dumps the prev[] region
// that follows the matrix. A one-cycle GAP separates every memory access.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

module graph_mem_loader #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [INDEX_WIDTH-1:0]   number_of_nodes,
  input  logic [MADDR_WIDTH-1:0]   base_address,
  graph_mem_loader_if.master       bus,
  output logic                     busy,
  output logic                     done,
  output logic [2*INDEX_WIDTH-1:0] mismatch_count,
  output logic [2*INDEX_WIDTH-1:0] first_mismatch,
  output logic [2:0]               state_dbg
);
  localparam int CW = 2*INDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR, S_GAP, S_VRD, S_RD, S_OUT, S_DONE
  } state_t;

  state_t                 state, state_nx;
  logic [1:0]             mode_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [MADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]          k_q;
  logic [VALUE_WIDTH-1:0] data_q;
  logic [MDATA_WIDTH-1:0] out_data_q;
  logic                   after_wr_q;

  logic [CW-1:0]          nn, count, word_idx;
  logic                   is_dump, last_word, read_bad, goto_verify;
  logic [MADDR_WIDTH-1:0] word_addr;
  logic [1:0]             start_mode;

  // Word bookkeeping: dump words sit right after the N*N matrix.
  assign nn          = CW'(n_q) * CW'(n_q);
  assign is_dump     = (mode_q == 2'd2);
  assign count       = is_dump ? CW'(n_q) : nn;
  assign last_word   = (k_q == count - CW'(1));
  assign word_idx    = is_dump ? (nn + k_q) : k_q;
  assign word_addr   = base_q + MADDR_WIDTH'(word_idx) * MADDR_WIDTH'(ADDR_STRIDE);
  assign read_bad    = (bus.mem_read_data != MDATA_WIDTH'(data_q));
  assign goto_verify = after_wr_q && (mode_q == 2'd1);
  assign start_mode  = (mode == 2'd3) ? 2'd0 : mode;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) begin
        if (number_of_nodes == '0)  state_nx = S_DONE;
        else if (start_mode == 2'd2) state_nx = S_RD;
        else                         state_nx = S_FETCH;
      end
      S_FETCH: if (bus.in_valid)        state_nx = S_WR;
      S_WR:    if (bus.mem_write_ready) state_nx = S_GAP;
      S_GAP: begin
        if (goto_verify)    state_nx = S_VRD;
        else if (last_word) state_nx = S_DONE;
        else if (is_dump)   state_nx = S_RD;
        else                state_nx = S_FETCH;
      end
      S_VRD:   if (bus.mem_read_ready) state_nx = S_GAP;
      S_RD:    if (bus.mem_read_ready) state_nx = S_OUT;
      S_OUT:   if (bus.out_ready)      state_nx = S_GAP;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: latch the request, the stream word, read data and verify results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q         <= '0;
      n_q            <= '0;
      base_q         <= '0;
      k_q            <= '0;
      data_q         <= '0;
      out_data_q     <= '0;
      after_wr_q     <= 1'b0;
      mismatch_count <= '0;
      first_mismatch <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q         <= start_mode;
          n_q            <= number_of_nodes;
          base_q         <= base_address;
          k_q            <= '0;
          mismatch_count <= '0;
          first_mismatch <= '0;
        end
        S_FETCH: if (bus.in_valid) data_q <= bus.in_data;
        S_WR:    if (bus.mem_write_ready) after_wr_q <= 1'b1;
        S_GAP: begin
          after_wr_q <= 1'b0;
          if (!goto_verify && !last_word) k_q <= k_q + CW'(1);
        end
        S_VRD: if (bus.mem_read_ready && read_bad) begin
          if (mismatch_count != {CW{1'b1}}) mismatch_count <= mismatch_count + CW'(1);
          if (mismatch_count == '0)         first_mismatch <= k_q;
        end
        S_RD: if (bus.mem_read_ready) out_data_q <= bus.mem_read_data;
        default: ;
      endcase
    end
  end

  // Outputs decoded from the current state; bus reads 0 when not accessing memory.
  always_comb begin
    bus.in_ready         = 1'b0;
    bus.out_valid        = 1'b0;
    bus.out_data         = out_data_q;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_write_data   = '0;
    busy                 = (state != S_IDLE) && (state != S_DONE);
    done                 = (state == S_DONE);
    state_dbg            = state;
    case (state)
      S_FETCH: bus.in_ready = 1'b1;
      S_WR: begin
        bus.mem_write_enable = 1'b1;
        bus.mem_addr         = word_addr;
        bus.mem_write_data   = MDATA_WIDTH'(data_q);
      end
      S_VRD, S_RD: begin
        bus.mem_read_enable = 1'b1;
        bus.mem_addr        = word_addr;
      end
      S_OUT:   bus.out_valid = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_graph_mem_loader.sv
// Directed bench for graph_mem_loader with a BlockRam model that has
// programmable write/read wait states and a one-address corruption hook.

module tb_graph_mem_loader;
  localparam int MAW = 16;
  localparam int MDW = 16;
  localparam int IW  = 8;
  localparam int VW  = 8;
  localparam int CW  = 2*IW;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [IW-1:0]  nn_in;
  logic [MAW-1:0] base_in;
  logic           busy, done;
  logic [CW-1:0]  mismatch_count, first_mismatch;
  logic [2:0]     state_dbg;

  graph_mem_loader_if #(.MADDR_WIDTH(MAW), .MDATA_WIDTH(MDW), .VALUE_WIDTH(VW)) bus ();

  graph_mem_loader #(
    .MADDR_WIDTH(MAW), .MDATA_WIDTH(MDW), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .ADDR_STRIDE(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .number_of_nodes(nn_in), .base_address(base_in), .bus(bus),
    .busy(busy), .done(done), .mismatch_count(mismatch_count),
    .first_mismatch(first_mismatch), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- memory model ----------------
  logic [MDW-1:0] mem_arr [0:1023];
  int             wr_delay, rd_delay;
  int             wcnt, rcnt, w_next, r_next;
  bit             corrupt_en;
  logic [MAW-1:0] corrupt_addr;

  assign bus.mem_write_ready = bus.mem_write_enable && (wcnt >= wr_delay);
  assign bus.mem_read_ready  = bus.mem_read_enable && (rcnt >= rd_delay);
  assign bus.mem_read_data   = mem_arr[bus.mem_addr[11:2]];

  // Observation state filled at the falling edge, where DUT outputs are settled.
  logic [MAW-1:0] wr_addr_q[$];
  logic [MDW-1:0] wr_data_q[$];
  int             wr_cyc_q[$];
  logic [MAW-1:0] rd_addr_q[$];
  logic [MDW-1:0] out_q[$];
  logic [MDW-1:0] exp_q[$];
  logic [VW-1:0]  stream_vals[$];
  int done_cnt, both_hi, en_cyc, wr_en_cyc, stab_err, cyc;
  bit             hold_v;
  logic [MAW-1:0] hold_a;
  logic [MDW-1:0] hold_d;

  always @(negedge clock) begin
    cyc++;
    w_next = 0;
    r_next = 0;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (bus.mem_write_enable && bus.mem_read_enable) both_hi++;
      if (bus.mem_write_enable || bus.mem_read_enable) en_cyc++;
      if (bus.mem_write_enable) begin
        wr_en_cyc++;
        if (hold_v && (bus.mem_addr !== hold_a || bus.mem_write_data !== hold_d)) stab_err++;
        hold_v = 1'b1;
        hold_a = bus.mem_addr;
        hold_d = bus.mem_write_data;
        if (bus.mem_write_ready) begin
          wr_addr_q.push_back(bus.mem_addr);
          wr_data_q.push_back(bus.mem_write_data);
          wr_cyc_q.push_back(cyc);
          mem_arr[bus.mem_addr[11:2]] = (corrupt_en && bus.mem_addr == corrupt_addr)
                                        ? 16'h00FF : bus.mem_write_data;
          hold_v = 1'b0;
        end else begin
          w_next = wcnt + 1;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (bus.mem_read_enable) begin
        if (bus.mem_read_ready) rd_addr_q.push_back(bus.mem_addr);
        else                    r_next = rcnt + 1;
      end
      if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
      if (done) done_cnt++;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt <= 0;
      rcnt <= 0;
    end else begin
      wcnt <= w_next;
      rcnt <= r_next;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); out_q.delete(); exp_q.delete();
    done_cnt = 0; both_hi = 0; en_cyc = 0; wr_en_cyc = 0; stab_err = 0;
  endtask

  task automatic pulse_start(input logic [1:0] m, input int n, input logic [MAW-1:0] b);
    @(posedge clock); #1;
    start = 1'b1; mode = m; nn_in = IW'(n); base_in = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic feed_stream(input int gap, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < stream_vals.size(); i++) begin
      int guard;
      bit hs;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clock);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stream_vals[i];
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 500) begin
        @(negedge clock);
        hs = bus.in_ready;
        @(posedge clock); #1;
        guard++;
      end
      if (!hs) begin
        ok = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.mem_read_enable, bus.mem_write_enable, busy, done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus.in_ready, bus.out_valid, bus.mem_read_enable, bus.mem_write_enable, busy, done});
    end
    tests_run++;
    if ({bus.mem_addr, bus.mem_write_data, bus.out_data, mismatch_count, first_mismatch} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h out=%h mc=%h fm=%h want all 0",
               bus.mem_addr, bus.mem_write_data, bus.out_data, mismatch_count, first_mismatch);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_load();
    bit ok_f, ok_d;
    clear_obs();
    wr_delay = 0; rd_delay = 0; corrupt_en = 1'b0;
    stream_vals.delete();
    for (int i = 0; i < 9; i++) begin
      stream_vals.push_back(VW'(i));
      exp_q.push_back(MDW'(i));
    end
    fork
      feed_stream(0, ok_f);
      pulse_start(2'd0, 3, 16'h0000);
      wait_done(200, ok_d);
    join
    repeat (5) @(negedge clock);
    tests_run++;
    if (!(ok_f && ok_d)) begin
      tests_failed++;
      $display("FAIL load_timeout: feed_ok=%0d done_ok=%0d want 1 1", ok_f, ok_d);
    end
    tests_run++;
    if (wr_addr_q.size() != 9) begin
      tests_failed++;
      $display("FAIL load_count: got %0d writes want 9", wr_addr_q.size());
    end
    for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== MAW'(4*i) || wr_data_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL load_word%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], MAW'(4*i), exp_q[i]);
      end
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      tests_run++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 3) begin
        tests_failed++;
        $display("FAIL load_latency%0d: got %0d cycles want 3", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (mem_arr[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL load_readback%0d: got %h want %h", i, mem_arr[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done_cnt != 1 || both_hi != 0) begin
      tests_failed++;
      $display("FAIL load_done: got done_pulses=%0d both_enables=%0d want 1 0", done_cnt, both_hi);
    end
  endtask

  task automatic test_dump();
    bit ok_d, stop;
    logic [MDW-1:0] pv [4];
    pv[0] = 16'd1; pv[1] = 16'd0; pv[2] = 16'd3; pv[3] = 16'd2;
    clear_obs();
    for (int i = 0; i < 4; i++) mem_arr[80 + i] = pv[i];
    stop = 1'b0;
    fork
      pulse_start(2'd2, 4, 16'h0100);
      begin
        wait_done(300, ok_d);
        stop = 1'b1;
      end
      for (int i = 0; i < 400 && !stop; i++) begin
        @(posedge clock); #1;
        bus.out_ready = ~bus.out_ready;
      end
    join
    bus.out_ready = 1'b0;
    repeat (5) @(negedge clock);
    tests_run++;
    if (!ok_d || out_q.size() != 4 || wr_addr_q.size() != 0) begin
      tests_failed++;
      $display("FAIL dump_count: done_ok=%0d outs=%0d writes=%0d want 1 4 0",
               ok_d, out_q.size(), wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== pv[i]) begin
        tests_failed++;
        $display("FAIL dump_data%0d: got %h want %h", i, out_q[i], pv[i]);
      end
    end
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++) begin
      tests_run++;
      if (rd_addr_q[i] !== MAW'(16'h0140 + 4*i)) begin
        tests_failed++;
        $display("FAIL dump_addr%0d: got %h want %h", i, rd_addr_q[i], MAW'(16'h0140 + 4*i));
      end
    end
    tests_run++;
    if (done_cnt != 1) begin
      tests_failed++;
      $display("FAIL dump_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_verify();
    bit ok_f, ok_d;
    clear_obs();
    corrupt_en = 1'b1; corrupt_addr = 16'h0008;
    stream_vals.delete();
    stream_vals.push_back(8'd4); stream_vals.push_back(8'd6);
    stream_vals.push_back(8'd5); stream_vals.push_back(8'd1);
    fork
      feed_stream(0, ok_f);
      pulse_start(2'd1, 2, 16'h0000);
      wait_done(300, ok_d);
    join
    repeat (5) @(negedge clock);
    corrupt_en = 1'b0;
    tests_run++;
    if (!(ok_f && ok_d) || wr_addr_q.size() != 4 || rd_addr_q.size() != 4) begin
      tests_failed++;
      $display("FAIL verify_flow: feed_ok=%0d done_ok=%0d writes=%0d reads=%0d want 1 1 4 4",
               ok_f, ok_d, wr_addr_q.size(), rd_addr_q.size());
    end
    tests_run++;
    if (mismatch_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL verify_count: got %0d want 1", mismatch_count);
    end
    tests_run++;
    if (first_mismatch !== CW'(2)) begin
      tests_failed++;
      $display("FAIL verify_first: got %0d want 2", first_mismatch);
    end
    for (int i = 1; i < wr_cyc_q.size(); i++) begin
      tests_run++;
      if (wr_cyc_q[i] - wr_cyc_q[i-1] != 5) begin
        tests_failed++;
        $display("FAIL verify_latency%0d: got %0d cycles want 5", i, wr_cyc_q[i] - wr_cyc_q[i-1]);
      end
    end
    tests_run++;
    if (done_cnt != 1 || both_hi != 0) begin
      tests_failed++;
      $display("FAIL verify_done: got done_pulses=%0d both_enables=%0d want 1 0", done_cnt, both_hi);
    end
  endtask

  task automatic test_n_zero();
    for (int mi = 0; mi < 2; mi++) begin
      logic [1:0] m;
      m = (mi == 0) ? 2'd0 : 2'd2;
      clear_obs();
      pulse_start(m, 0, 16'h0040);
      @(negedge clock);
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL nzero_done_m%0d: got done=%b busy=%b want 1 0", m, done, busy);
      end
      @(negedge clock);
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++;
        $display("FAIL nzero_pulse_m%0d: got done=%b want 0", m, done);
      end
      repeat (3) @(negedge clock);
      tests_run++;
      if (en_cyc != 0 || done_cnt != 1) begin
        tests_failed++;
        $display("FAIL nzero_quiet_m%0d: got enable_cycles=%0d done_pulses=%0d want 0 1", m, en_cyc, done_cnt);
      end
      tests_run++;
      if (mismatch_count !== '0 || first_mismatch !== '0) begin
        tests_failed++;
        $display("FAIL nzero_clear_m%0d: got mc=%0d fm=%0d want 0 0", m, mismatch_count, first_mismatch);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen_wr, ok_f, ok_d;
    clear_obs();
    wr_delay = 1000;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    pulse_start(2'd0, 8, 16'h0000);
    seen_wr = 1'b0;
    for (int i = 0; i < 20 && !seen_wr; i++) begin
      @(negedge clock);
      seen_wr = bus.mem_write_enable;
    end
    tests_run++;
    if (!seen_wr) begin
      tests_failed++;
      $display("FAIL rstmid_reach_wr: got no write request want one within 20 cycles");
    end
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.mem_read_enable, bus.mem_write_enable, busy, done} !== 6'b0 ||
        {bus.mem_addr, bus.mem_write_data, bus.out_data, mismatch_count, first_mismatch} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: ctl=%b addr=%h wdata=%h out=%h mc=%h fm=%h want all 0",
               {bus.in_ready, bus.out_valid, bus.mem_read_enable, bus.mem_write_enable, busy, done},
               bus.mem_addr, bus.mem_write_data, bus.out_data, mismatch_count, first_mismatch);
    end
    @(posedge clock); #1;
    tests_run++;
    if ({bus.mem_write_enable, busy, done, state_dbg} !== 6'b0 || done_cnt != 0) begin
      tests_failed++;
      $display("FAIL rstmid_edge: we=%b busy=%b done=%b state=%0d done_pulses=%0d want 0 0 0 0 0",
               bus.mem_write_enable, busy, done, state_dbg, done_cnt);
    end
    reset = 1'b0;
    wr_delay = 0;
    clear_obs();
    stream_vals.delete();
    for (int i = 0; i < 64; i++) begin
      stream_vals.push_back(VW'((i*5 + 3) & 8'hFF));
      exp_q.push_back(MDW'((i*5 + 3) & 8'hFF));
    end
    // Mode 3 behaves as a plain load: no verify reads expected.
    fork
      feed_stream(0, ok_f);
      pulse_start(2'd3, 8, 16'h0000);
      wait_done(1500, ok_d);
    join
    repeat (5) @(negedge clock);
    tests_run++;
    if (!(ok_f && ok_d) || wr_addr_q.size() != 64 || rd_addr_q.size() != 0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL rstmid_rerun: feed_ok=%0d done_ok=%0d writes=%0d reads=%0d done_pulses=%0d want 1 1 64 0 1",
               ok_f, ok_d, wr_addr_q.size(), rd_addr_q.size(), done_cnt);
    end
    for (int i = 0; i < 64 && i < wr_addr_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== MAW'(4*i) || wr_data_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rstmid_word%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], MAW'(4*i), exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok_f, ok_d;
    clear_obs();
    wr_delay = 3;
    stream_vals.delete();
    stream_vals.push_back(8'h11); stream_vals.push_back(8'h22);
    stream_vals.push_back(8'h33); stream_vals.push_back(8'h44);
    exp_q.push_back(16'h0011); exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0033); exp_q.push_back(16'h0044);
    fork
      feed_stream(2, ok_f);
      begin
        pulse_start(2'd0, 2, 16'h0020);
        repeat (6) @(posedge clock);
        pulse_start(2'd2, 1, 16'h0300);
      end
      wait_done(400, ok_d);
    join
    repeat (10) @(negedge clock);
    wr_delay = 0;
    tests_run++;
    if (!(ok_f && ok_d) || wr_addr_q.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_flow: feed_ok=%0d done_ok=%0d writes=%0d want 1 1 4", ok_f, ok_d, wr_addr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== MAW'(16'h0020 + 4*i) || wr_data_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL stall_word%0d: got addr=%h data=%h want addr=%h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], MAW'(16'h0020 + 4*i), exp_q[i]);
      end
    end
    tests_run++;
    if (stab_err != 0 || wr_en_cyc != 16) begin
      tests_failed++;
      $display("FAIL stall_hold: got unstable=%0d write_cycles=%0d want 0 16", stab_err, wr_en_cyc);
    end
    tests_run++;
    if (done_cnt != 1 || rd_addr_q.size() != 0 || out_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_ignore_start: done_pulses=%0d reads=%0d outs=%0d busy=%b want 1 0 0 0",
               done_cnt, rd_addr_q.size(), out_q.size(), busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; nn_in = '0; base_in = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    wr_delay = 0; rd_delay = 0; corrupt_en = 1'b0; corrupt_addr = '0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
    test_reset();
    test_load();
    test_dump();
    test_verify();
    test_n_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
